// File: rtl/fpdiv_ctrl_if.sv
// rtl/fpdiv_ctrl_if.sv - request and datapath-control bundle for the Goldschmidt sequencer
interface fpdiv_ctrl_if;
  logic        start;
  logic [31:0] in_num;
  logic [31:0] in_denom;
  logic        in_rm;
  logic [31:0] inputNum;
  logic [31:0] inputDenom;
  logic        rm;
  logic        en_a;
  logic        en_b;
  logic        en_rem;
  logic [1:0]  sel_mux3;
  logic [1:0]  sel_mux4;
  logic        busy;
  logic        done;

  modport master (
    output start, in_num, in_denom, in_rm,
    input  inputNum, inputDenom, rm, en_a, en_b, en_rem,
    input  sel_mux3, sel_mux4, busy, done
  );

  modport slave (
    input  start, in_num, in_denom, in_rm,
    output inputNum, inputDenom, rm, en_a, en_b, en_rem,
    output sel_mux3, sel_mux4, busy, done
  );
endinterface

// File: rtl/fpdiv_ctrl.sv
// rtl/fpdiv_ctrl.sv - sequencer for the Goldschmidt mantissa divider datapath
module fpdiv_ctrl #(
  parameter int ITERS = 3
) (
  input logic        clk,
  input logic        reset,
  fpdiv_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_NUM0 = 3'd1,
    S_DEN0 = 3'd2,
    S_ITN  = 3'd3,
    S_ITD  = 3'd4,
    S_REM  = 3'd5,
    S_DONE = 3'd6
  } state_e;

  localparam logic [2:0] LAST_ITER = 3'(ITERS - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        accept;
  logic [31:0] num_q, den_q;
  logic        rm_q;
  logic        en_a_q, en_b_q, en_rem_q, busy_q, done_q;
  logic [1:0]  sel3_q, sel4_q, sel3_d, sel4_d;

  always_comb begin
    state_d = S_IDLE;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          accept  = 1'b1;
          cnt_d   = 3'd0;
          state_d = S_NUM0;
        end
      end
      S_NUM0: state_d = S_DEN0;
      S_DEN0: state_d = S_ITN;
      // ITN always runs before ITD so both chains in a pass share one K
      S_ITN:  state_d = S_ITD;
      S_ITD: begin
        if (cnt_q == LAST_ITER) begin
          cnt_d   = 3'd0;
          state_d = S_REM;
        end else begin
          cnt_d   = cnt_q + 3'd1;
          state_d = S_ITN;
        end
      end
      S_REM:  state_d = S_DONE;
      default: begin
        cnt_d   = 3'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    sel3_d = 2'd0;
    sel4_d = 2'd0;
    case (state_d)
      S_DEN0: sel4_d = 2'd1;
      S_ITN:  begin sel3_d = 2'd1; sel4_d = 2'd2; end
      S_ITD:  begin sel3_d = 2'd1; sel4_d = 2'd3; end
      S_REM:  begin sel3_d = 2'd2; sel4_d = 2'd2; end
      default: begin sel3_d = 2'd0; sel4_d = 2'd0; end
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      num_q    <= 32'd0;
      den_q    <= 32'd0;
      rm_q     <= 1'b0;
      en_a_q   <= 1'b0;
      en_b_q   <= 1'b0;
      en_rem_q <= 1'b0;
      sel3_q   <= 2'd0;
      sel4_q   <= 2'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        num_q <= bus.in_num;
        den_q <= bus.in_denom;
        rm_q  <= bus.in_rm;
      end
      en_a_q   <= (state_d == S_NUM0) || (state_d == S_ITN);
      en_b_q   <= (state_d == S_DEN0) || (state_d == S_ITD);
      en_rem_q <= (state_d == S_REM);
      sel3_q   <= sel3_d;
      sel4_q   <= sel4_d;
      busy_q   <= (state_d == S_NUM0) || (state_d == S_DEN0) || (state_d == S_ITN) ||
                  (state_d == S_ITD)  || (state_d == S_REM);
      done_q   <= (state_d == S_DONE);
    end
  end

  assign bus.inputNum   = num_q;
  assign bus.inputDenom = den_q;
  assign bus.rm         = rm_q;
  assign bus.en_a       = en_a_q;
  assign bus.en_b       = en_b_q;
  assign bus.en_rem     = en_rem_q;
  assign bus.sel_mux3   = sel3_q;
  assign bus.sel_mux4   = sel4_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_fpdiv_ctrl.sv
// tb/tb_fpdiv_ctrl.sv - scoreboard bench for fpdiv_ctrl, ITERS=3 and ITERS=1 builds side by side
module tb_fpdiv_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] in_num = 32'd0;
  logic [31:0] in_denom = 32'd0;
  logic        in_rm = 1'b0;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;

  typedef struct {
    logic [31:0] num;
    logic [31:0] den;
    logic        rm;
    int          due;
  } sb_t;

  sb_t         sbq [2][$];
  int          pos [2];
  logic [31:0] h_num [2];
  logic [31:0] h_den [2];
  logic        h_rm [2];
  int          n_of [2] = '{3, 1};

  logic [8:0]  act_ctrl [2];
  logic [31:0] act_num [2];
  logic [31:0] act_den [2];
  logic        act_rm [2];

  fpdiv_ctrl_if bus3 ();
  fpdiv_ctrl_if bus1 ();

  fpdiv_ctrl #(.ITERS(3)) dut3 (.clk(clk), .reset(rst_n), .bus(bus3));
  fpdiv_ctrl #(.ITERS(1)) dut1 (.clk(clk), .reset(rst_n), .bus(bus1));

  assign bus3.start = start;  assign bus3.in_num = in_num;
  assign bus3.in_denom = in_denom;  assign bus3.in_rm = in_rm;
  assign bus1.start = start;  assign bus1.in_num = in_num;
  assign bus1.in_denom = in_denom;  assign bus1.in_rm = in_rm;

  assign act_ctrl[0] = {bus3.en_a, bus3.en_b, bus3.en_rem, bus3.sel_mux3, bus3.sel_mux4, bus3.busy, bus3.done};
  assign act_ctrl[1] = {bus1.en_a, bus1.en_b, bus1.en_rem, bus1.sel_mux3, bus1.sel_mux4, bus1.busy, bus1.done};
  assign act_num[0] = bus3.inputNum;   assign act_num[1] = bus1.inputNum;
  assign act_den[0] = bus3.inputDenom; assign act_den[1] = bus1.inputDenom;
  assign act_rm[0]  = bus3.rm;         assign act_rm[1]  = bus1.rm;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int k, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s dut%0d actual=%h required=%h t=%0t", nm, k, a, e, $time);
    end
  endtask

  // Expected {en_a,en_b,en_rem,sel3,sel4,busy,done} for cycle p of an operation (0 = idle)
  function automatic logic [8:0] ctrl_for(input int p, input int n);
    if (p == 0) return 9'b0;
    if (p == 1) return {3'b100, 2'd0, 2'd0, 2'b10};
    if (p == 2) return {3'b010, 2'd0, 2'd1, 2'b10};
    if (p <= 2 * n + 2) begin
      if (((p - 3) % 2) == 0) return {3'b100, 2'd1, 2'd2, 2'b10};
      return {3'b010, 2'd1, 2'd3, 2'b10};
    end
    if (p == 2 * n + 3) return {3'b001, 2'd2, 2'd2, 2'b10};
    return {3'b000, 2'd0, 2'd0, 2'b01};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        pos[k] = 0; h_num[k] = 32'd0; h_den[k] = 32'd0; h_rm[k] = 1'b0;
        sbq[k].delete();
      end
    end else begin
      edge_n++;
      for (int k = 0; k < 2; k++) begin
        int len;
        len = 2 * n_of[k] + 4;
        if ((pos[k] == 0 || pos[k] == len) && start) begin
          pos[k] = 1;
          h_num[k] = in_num; h_den[k] = in_denom; h_rm[k] = in_rm;
          sbq[k].push_back('{num: in_num, den: in_denom, rm: in_rm, due: edge_n + len - 1});
        end else if (pos[k] == 0 || pos[k] == len) begin
          pos[k] = 0;
        end else begin
          pos[k] = pos[k] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      sb_t it;
      chk("ctrl", k, 64'(act_ctrl[k]), 64'(ctrl_for(pos[k], n_of[k])));
      chk("held_ops", k, {act_num[k], act_den[k][31:1], act_rm[k]}, {h_num[k], h_den[k][31:1], h_rm[k]});
      chk("invariants", k,
          64'({act_ctrl[k][8] & act_ctrl[k][7],
               act_ctrl[k][6] & (act_ctrl[k][5:4] != 2'd2),
               act_ctrl[k][1] & act_ctrl[k][0],
               act_ctrl[k][5:4] == 2'd3}), 64'd0);
      if (act_ctrl[k][0]) begin
        if (sbq[k].size() == 0) begin
          chk("done_unexpected", k, 64'd1, 64'd0);
        end else begin
          it = sbq[k].pop_front();
          chk("done_num", k, 64'(act_num[k]), 64'(it.num));
          chk("done_den", k, 64'(act_den[k]), 64'(it.den));
          chk("done_rm", k, 64'(act_rm[k]), 64'(it.rm));
          chk("done_edge", k, 64'(edge_n), 64'(it.due));
        end
      end
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat [2];
    int itn_cnt [2];
    int rem_cnt [2];

    step(3);
    chk("reset_ctrl", 0, 64'(act_ctrl[0]), 64'd0);
    chk("reset_ops", 0, 64'(act_num[0]), 64'd0);
    rst_n = 1'b1;
    step(3);

    // Directed operation with latency and pass counting
    in_num = 32'h3FC0_0000; in_denom = 32'h3FA0_0000; in_rm = 1'b1; start = 1'b1;
    step();
    start = 1'b0; in_num = 32'h1234_5678;
    lat = '{-1, -1}; itn_cnt = '{0, 0}; rem_cnt = '{0, 0};
    for (int i = 1; i <= 14; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (act_ctrl[k][8] && act_ctrl[k][5:4] == 2'd1) itn_cnt[k]++;
        if (act_ctrl[k][6]) rem_cnt[k]++;
      end
      step();
      if (lat[0] < 0 && bus3.done) lat[0] = i;
      if (lat[1] < 0 && bus1.done) lat[1] = i;
    end
    chk("latency", 0, 64'(lat[0]), 64'd9);
    chk("latency", 1, 64'(lat[1]), 64'd5);
    chk("itn_passes", 0, 64'(itn_cnt[0]), 64'd3);
    chk("itn_passes", 1, 64'(itn_cnt[1]), 64'd1);
    chk("rem_cycles", 0, 64'(rem_cnt[0]), 64'd1);
    chk("rem_cycles", 1, 64'(rem_cnt[1]), 64'd1);

    // Start held high: back-to-back, operands reload at each DONE
    start = 1'b1;
    for (int i = 0; i < 45; i++) begin
      in_num = $urandom; in_denom = $urandom; in_rm = 1'($urandom_range(0, 1));
      step();
    end
    start = 1'b0;
    step(12);

    // Start pulsed while busy is ignored
    in_num = 32'hAAAA_0001; in_denom = 32'h5555_0002; start = 1'b1;
    step();
    start = 1'b0;
    step(2);
    in_num = 32'hDEAD_BEEF; start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_ignore", 0, 64'(act_num[0]), 64'hAAAA_0001);
    step(12);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      start = ($urandom_range(0, 3) == 0);
      in_num = $urandom; in_denom = $urandom; in_rm = 1'($urandom_range(0, 1));
      step();
    end
    start = 1'b0;
    step(12);

    // Reset asserted mid-ITD
    start = 1'b1; in_num = $urandom; in_denom = $urandom;
    step();
    start = 1'b0;
    step(3);
    chk("in_itd", 0, 64'(act_ctrl[0]), 64'({3'b010, 2'd1, 2'd3, 2'b10}));
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("async_reset_ctrl", k, 64'(act_ctrl[k]), 64'd0);
      chk("async_reset_ops", k, {act_num[k], act_den[k]}, 64'd0);
    end
    step(2);
    rst_n = 1'b1;
    in_num = $urandom;
    step(15);

    for (int k = 0; k < 2; k++) chk("sb_drained", k, 64'(sbq[k].size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
